// File: rtl/ir_nec_pkg.sv
// Shared types and constants for the NEC IR receiver: FSM states, pulse-width
// windows (in half-units of T = 562.5 us) and error codes.
package ir_nec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD_LO,
    ST_LEAD_HI,
    ST_BIT_LO,
    ST_BIT_HI,
    ST_STOP_LO,
    ST_CHECK,
    ST_REP_LO
  } state_t;

  localparam logic [5:0] LEAD_LO_MIN = 6'd28;
  localparam logic [5:0] LEAD_LO_MAX = 6'd36;
  localparam logic [5:0] LEAD_HI_MIN = 6'd14;
  localparam logic [5:0] LEAD_HI_MAX = 6'd18;
  localparam logic [5:0] REP_HI_MIN  = 6'd7;
  localparam logic [5:0] REP_HI_MAX  = 6'd10;
  localparam logic [5:0] BURST_MIN   = 6'd1;
  localparam logic [5:0] BURST_MAX   = 6'd3;
  localparam logic [5:0] ZERO_MIN    = 6'd1;
  localparam logic [5:0] ZERO_MAX    = 6'd3;
  localparam logic [5:0] ONE_MIN     = 6'd4;
  localparam logic [5:0] ONE_MAX     = 6'd8;
  localparam logic [5:0] H_SAT       = 6'd63;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_TIMING   = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;
  localparam logic [1:0] ERR_OVERRUN  = 2'd3;

  function automatic logic in_window(input logic [5:0] h, input logic [5:0] lo,
                                     input logic [5:0] hi);
    return (h >= lo) && (h <= hi);
  endfunction

endpackage

// File: rtl/ir_nec_receiver_edge_sync.sv
// Reset synchroniser (async assert, sync release), IR line synchroniser,
// history flop and registered fall/rise strobes for the NEC receiver.
module ir_edge_sync
  import ir_nec_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Serial,
  output logic rst_int,
  output logic fall,
  output logic rise
);

  logic [1:0]             rst_pipe;
  logic [SYNC_STAGES-1:0] sync;
  logic                   cur;
  logic                   hist;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) rst_pipe <= 2'b11;
    else       rst_pipe <= {rst_pipe[0], 1'b0};
  end

  assign rst_int = rst_pipe[1];
  assign cur     = sync[SYNC_STAGES-1];

  // Idle line is high, so the chain resets to 1 to avoid a spurious fall.
  always_ff @(posedge Clock or posedge rst_int) begin
    if (rst_int) begin
      sync <= '1;
      hist <= 1'b1;
      fall <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], Serial};
      hist <= cur;
      fall <= hist & ~cur;
      rise <= ~hist & cur;
    end
  end

endmodule

// File: rtl/ir_nec_receiver.sv
// NEC IR frame receiver: pulse-width decoding FSM with valid/ready output.
// Define IR_REPEAT_EN to replay the last good frame on a repeat code.
module ir_nec_receiver
  import ir_nec_pkg::*;
#(
  parameter int UNIT_CYCLES = 28125,
  parameter int SYNC_STAGES = 2,
  parameter bit EXT_ADDR    = 1'b0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Serial,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_addr,
  output logic [7:0]  out_cmd,
  output logic        out_repeat,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam int HALF = UNIT_CYCLES / 2;
  localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic          rst_int, fall, rise, any_edge;
  logic [PW-1:0] presc;
  logic [5:0]    h;

  state_t        state_reg, state_next;
  logic [5:0]    bit_cnt_reg, bit_cnt_next;
  logic [31:0]   shreg_reg, shreg_next;
  logic          abort, csum_fail, frame_ok, rep_ok, rep_load, load_req, load_rep;
  logic [15:0]   frame_addr, load_addr;
  logic [7:0]    frame_cmd, load_cmd;

  logic          out_valid_reg, out_valid_next;
  logic [15:0]   out_addr_reg, out_addr_next;
  logic [7:0]    out_cmd_reg, out_cmd_next;
  logic          out_repeat_reg, out_repeat_next;
  logic          err_reg, err_next;
  logic [1:0]    err_code_reg, err_code_next;

  ir_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .Clock   (Clock),
    .Reset   (Reset),
    .Serial  (Serial),
    .rst_int (rst_int),
    .fall    (fall),
    .rise    (rise)
  );

  assign any_edge = fall | rise;

  // h counts half-units since the last edge; the value seen with a strobe is the pulse width.
  always_ff @(posedge Clock or posedge rst_int) begin
    if (rst_int) begin
      presc <= '0;
      h     <= '0;
    end else if (any_edge) begin
      presc <= '0;
      h     <= '0;
    end else if (presc == PW'(HALF - 1)) begin
      presc <= '0;
      if (h != H_SAT) h <= h + 6'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign frame_addr = EXT_ADDR ? shreg_reg[15:0] : {8'h00, shreg_reg[7:0]};
  assign frame_cmd  = shreg_reg[23:16];

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shreg_next   = shreg_reg;
    abort        = 1'b0;
    csum_fail    = 1'b0;
    frame_ok     = 1'b0;
    rep_ok       = 1'b0;
    if (state_reg != ST_IDLE && h == H_SAT) begin
      abort = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (fall) begin
            state_next   = ST_LEAD_LO;
            bit_cnt_next = '0;
          end
        end
        ST_LEAD_LO: begin
          if (rise) begin
            if (in_window(h, LEAD_LO_MIN, LEAD_LO_MAX)) state_next = ST_LEAD_HI;
            else abort = 1'b1;
          end
        end
        ST_LEAD_HI: begin
          if (fall) begin
            if (in_window(h, LEAD_HI_MIN, LEAD_HI_MAX))     state_next = ST_BIT_LO;
            else if (in_window(h, REP_HI_MIN, REP_HI_MAX)) state_next = ST_REP_LO;
            else abort = 1'b1;
          end
        end
        ST_BIT_LO: begin
          if (rise) begin
            if (in_window(h, BURST_MIN, BURST_MAX)) state_next = ST_BIT_HI;
            else abort = 1'b1;
          end
        end
        ST_BIT_HI: begin
          if (fall) begin
            if (in_window(h, ZERO_MIN, ZERO_MAX) || in_window(h, ONE_MIN, ONE_MAX)) begin
              shreg_next   = {in_window(h, ONE_MIN, ONE_MAX), shreg_reg[31:1]};
              bit_cnt_next = bit_cnt_reg + 6'd1;
              state_next   = (bit_cnt_reg == 6'd31) ? ST_STOP_LO : ST_BIT_LO;
            end else begin
              abort = 1'b1;
            end
          end
        end
        ST_STOP_LO: begin
          if (rise) begin
            if (in_window(h, BURST_MIN, BURST_MAX)) state_next = ST_CHECK;
            else abort = 1'b1;
          end
        end
        ST_CHECK: begin
          state_next = ST_IDLE;
          if ((shreg_reg[31:24] == ~shreg_reg[23:16]) &&
              (EXT_ADDR || (shreg_reg[15:8] == ~shreg_reg[7:0])))
            frame_ok = 1'b1;
          else
            csum_fail = 1'b1;
        end
        ST_REP_LO: begin
          if (rise) begin
            if (in_window(h, BURST_MIN, BURST_MAX)) begin
              state_next = ST_IDLE;
              rep_ok     = 1'b1;
            end else begin
              abort = 1'b1;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
    if (abort) state_next = ST_IDLE;
  end

`ifdef IR_REPEAT_EN
  logic        last_valid_reg;
  logic [15:0] last_addr_reg;
  logic [7:0]  last_cmd_reg;

  always_ff @(posedge Clock or posedge rst_int) begin
    if (rst_int) begin
      last_valid_reg <= 1'b0;
      last_addr_reg  <= '0;
      last_cmd_reg   <= '0;
    end else if (frame_ok) begin
      last_valid_reg <= 1'b1;
      last_addr_reg  <= frame_addr;
      last_cmd_reg   <= frame_cmd;
    end
  end

  assign rep_load  = rep_ok & last_valid_reg;
  assign load_addr = frame_ok ? frame_addr : last_addr_reg;
  assign load_cmd  = frame_ok ? frame_cmd  : last_cmd_reg;
  assign load_rep  = ~frame_ok;
`else
  // Repeat codes are still width-checked but never produce a result.
  assign rep_load  = rep_ok & 1'b0;
  assign load_addr = frame_addr;
  assign load_cmd  = frame_cmd;
  assign load_rep  = 1'b0;
`endif

  assign load_req = frame_ok | rep_load;

  always_comb begin
    out_valid_next  = out_valid_reg & ~out_ready;
    out_addr_next   = out_addr_reg;
    out_cmd_next    = out_cmd_reg;
    out_repeat_next = out_repeat_reg;
    err_next        = 1'b0;
    err_code_next   = err_code_reg;
    if (load_req) begin
      // A pending result that is not being taken this cycle wins over the new one.
      if (!out_valid_reg || out_ready) begin
        out_valid_next  = 1'b1;
        out_addr_next   = load_addr;
        out_cmd_next    = load_cmd;
        out_repeat_next = load_rep;
      end else begin
        err_next      = 1'b1;
        err_code_next = ERR_OVERRUN;
      end
    end
    if (abort) begin
      err_next      = 1'b1;
      err_code_next = ERR_TIMING;
    end
    if (csum_fail) begin
      err_next      = 1'b1;
      err_code_next = ERR_CHECKSUM;
    end
  end

  always_ff @(posedge Clock or posedge rst_int) begin
    if (rst_int) begin
      state_reg      <= ST_IDLE;
      bit_cnt_reg    <= '0;
      shreg_reg      <= '0;
      out_valid_reg  <= 1'b0;
      out_addr_reg   <= '0;
      out_cmd_reg    <= '0;
      out_repeat_reg <= 1'b0;
      err_reg        <= 1'b0;
      err_code_reg   <= ERR_NONE;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shreg_reg      <= shreg_next;
      out_valid_reg  <= out_valid_next;
      out_addr_reg   <= out_addr_next;
      out_cmd_reg    <= out_cmd_next;
      out_repeat_reg <= out_repeat_next;
      err_reg        <= err_next;
      err_code_reg   <= err_code_next;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_addr   = out_addr_reg;
  assign out_cmd    = out_cmd_reg;
  assign out_repeat = out_repeat_reg;
  assign err        = err_reg;
  assign err_code   = err_code_reg;
  assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ir_nec_receiver.sv
// Directed bench for ir_nec_receiver at UNIT_CYCLES=8: frame table plus
// repeat, short-leader, overrun and mid-frame reset sequences.
module tb_ir_nec_receiver;

  localparam int UNIT   = 8;
  localparam int HALF   = UNIT / 2;
  localparam int SYNC   = 2;
  localparam int LAT    = SYNC + 3;
  localparam int W_ANY  = 0;
  localparam int W_ERR  = 1;
  localparam int W_BUSY = 2;
`ifdef IR_REPEAT_EN
  localparam int REP_RESULTS = 1;
`else
  localparam int REP_RESULTS = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        serial = 1'b1;
  logic        out_ready = 1'b1;
  logic        out_valid, out_repeat, err, busy;
  logic [15:0] out_addr;
  logic [7:0]  out_cmd;
  logic [1:0]  err_code;

  int checks = 0;
  int failures = 0;
  int n_accept = 0;
  int n_err = 0;

  ir_nec_receiver #(.UNIT_CYCLES(UNIT), .SYNC_STAGES(SYNC), .EXT_ADDR(1'b0)) dut (
    .Clock      (clock),
    .Reset      (reset),
    .Serial     (serial),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_cmd    (out_cmd),
    .out_repeat (out_repeat),
    .err        (err),
    .err_code   (err_code),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (out_valid && out_ready) n_accept++;
    if (err) n_err++;
  end

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic        exp_valid;
    logic [15:0] exp_addr;
    logic [7:0]  exp_cmd;
    logic [1:0]  exp_code;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic level, input int halves);
    serial = level;
    repeat (halves * HALF) @(posedge clock);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 2);
      drive(1'b1, data[i] ? 6 : 2);
    end
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    drive(1'b0, 32);
    drive(1'b1, 16);
    send_bits({b3, b2, b1, b0}, 32);
    drive(1'b0, 2);
    serial = 1'b1;
  endtask

  task automatic send_repeat();
    drive(1'b0, 32);
    drive(1'b1, 8);
    drive(1'b0, 2);
    serial = 1'b1;
  endtask

  // Returns the cycle count until the awaited condition, or 0 if the bound expired.
  task automatic wait_for(input int what, input int limit, output int lat);
    int  i;
    bit  hit;
    i = 0;
    hit = 1'b0;
    lat = 0;
    while (!hit && i < limit) begin
      @(posedge clock);
      #1;
      i++;
      case (what)
        W_ANY:   hit = out_valid || err;
        W_ERR:   hit = err;
        default: hit = busy;
      endcase
    end
    if (hit) lat = i;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"},  out_valid, 0);
    check({tag, "_addr"},   out_addr, 0);
    check({tag, "_cmd"},    out_cmd, 0);
    check({tag, "_repeat"}, out_repeat, 0);
    check({tag, "_err"},    err, 0);
    check({tag, "_code"},   err_code, 0);
    check({tag, "_busy"},   busy, 0);
  endtask

  initial begin
    int lat;
    int acc0;

    vecs[0] = '{8'h04, 8'hFB, 8'h16, 8'hE9, 1'b1, 16'h0004, 8'h16, 2'd0};
    vecs[1] = '{8'h04, 8'hFB, 8'h16, 8'hE8, 1'b0, 16'h0000, 8'h00, 2'd2};
    vecs[2] = '{8'hA5, 8'h5A, 8'h3C, 8'hC3, 1'b1, 16'h00A5, 8'h3C, 2'd0};
    vecs[3] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 1'b1, 16'h0000, 8'h00, 2'd0};
    vecs[4] = '{8'h12, 8'h34, 8'h56, 8'hA9, 1'b0, 16'h0000, 8'h00, 2'd2};
    vecs[5] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 1'b1, 16'h00FF, 8'hFF, 2'd0};

    repeat (3) @(posedge clock);
    #1;
    check_reset_values("reset_in");
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check_reset_values("reset_out");

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3);
      wait_for(W_ANY, 40, lat);
      check("vec_latency", lat, LAT);
      check("vec_valid", out_valid, vecs[v].exp_valid);
      check("vec_err", err, !vecs[v].exp_valid);
      if (vecs[v].exp_valid) begin
        check("vec_addr", out_addr, vecs[v].exp_addr);
        check("vec_cmd", out_cmd, vecs[v].exp_cmd);
        check("vec_repeat", out_repeat, 0);
      end else begin
        check("vec_code", err_code, vecs[v].exp_code);
      end
      $display("vector %0d: bytes %h %h %h %h -> valid=%0b addr=%h cmd=%h err=%0b code=%0d",
               v, vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3,
               out_valid, out_addr, out_cmd, err, err_code);
      drive(1'b1, 8);
    end

    // Frame followed by a repeat code.
    send_frame(8'h04, 8'hFB, 8'h16, 8'hE9);
    wait_for(W_ANY, 40, lat);
    check("rep_frame_valid", out_valid, 1);
    check("rep_frame_cmd", out_cmd, 8'h16);
    drive(1'b1, 16);
    send_repeat();
    wait_for(W_ANY, 40, lat);
`ifdef IR_REPEAT_EN
    check("rep_latency", lat, SYNC + 2);
    check("rep_valid", out_valid, 1);
    check("rep_flag", out_repeat, 1);
    check("rep_addr", out_addr, 16'h0004);
    check("rep_cmd", out_cmd, 8'h16);
`else
    check("rep_ignored", lat, 0);
`endif
    $display("repeat: latency=%0d valid=%0b repeat=%0b addr=%h cmd=%h", lat, out_valid,
             out_repeat, out_addr, out_cmd);
    drive(1'b1, 8);

    // Leader low cut to 20 half-units.
    serial = 1'b0;
    wait_for(W_BUSY, 20, lat);
    check("busy_rise_latency", lat, SYNC + 2);
    repeat (20 * HALF - lat) @(posedge clock);
    #1;
    serial = 1'b1;
    wait_for(W_ANY, 40, lat);
    check("short_latency", lat, SYNC + 2);
    check("short_err", err, 1);
    check("short_code", err_code, 1);
    check("short_valid", out_valid, 0);
    check("short_busy", busy, 0);
    $display("short leader: err=%0b code=%0d busy=%0b", err, err_code, busy);
    drive(1'b1, 8);
    send_frame(8'hA5, 8'h5A, 8'h3C, 8'hC3);
    wait_for(W_ANY, 40, lat);
    check("recover_valid", out_valid, 1);
    check("recover_addr", out_addr, 16'h00A5);
    check("recover_cmd", out_cmd, 8'h3C);
    $display("recovery frame: valid=%0b addr=%h cmd=%h", out_valid, out_addr, out_cmd);
    drive(1'b1, 8);

    // Overrun: consumer stalled across two frames.
    out_ready = 1'b0;
    acc0 = n_accept;
    send_frame(8'h04, 8'hFB, 8'h16, 8'hE9);
    wait_for(W_ANY, 40, lat);
    check("ovr_first_valid", out_valid, 1);
    drive(1'b1, 8);
    send_frame(8'hA5, 8'h5A, 8'h3C, 8'hC3);
    wait_for(W_ERR, 40, lat);
    check("ovr_latency", lat, LAT);
    check("ovr_code", err_code, 3);
    check("ovr_valid_held", out_valid, 1);
    check("ovr_addr_held", out_addr, 16'h0004);
    check("ovr_cmd_held", out_cmd, 8'h16);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    check("ovr_drained", out_valid, 0);
    check("ovr_accepts", n_accept - acc0, 1);
    $display("overrun: code=%0d held addr=%h cmd=%h accepts=%0d", err_code, out_addr,
             out_cmd, n_accept - acc0);
    drive(1'b1, 8);

    // Reset in the middle of bit 10.
    drive(1'b0, 32);
    drive(1'b1, 16);
    send_bits(32'hE916FB04, 10);
    drive(1'b0, 1);
    reset = 1'b1;
    #2;
    check_reset_values("midreset");
    serial = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("midreset_busy_after", busy, 0);
    send_repeat();
    wait_for(W_ANY, 40, lat);
    check("rep_after_reset_ignored", lat, 0);
    drive(1'b1, 8);
    send_frame(8'h80, 8'h7F, 8'h01, 8'hFE);
    wait_for(W_ANY, 40, lat);
    check("post_reset_latency", lat, LAT);
    check("post_reset_valid", out_valid, 1);
    check("post_reset_addr", out_addr, 16'h0080);
    check("post_reset_cmd", out_cmd, 8'h01);
    $display("post-reset frame: valid=%0b addr=%h cmd=%h", out_valid, out_addr, out_cmd);
    drive(1'b1, 4);

    check("total_errors", n_err, 4);
    check("total_accepts", n_accept, 8 + REP_RESULTS);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
